nios_ram_block_mover: RTL

//  Avalon-MM master that drives the single-port on-chip RAM slave: chipselect, write, byteenable, address and writedata out; readdata in.
//  The RAM has a fixed read latency of 1 and no waitrequest.

---
 rtl/nios_ram_mover_pkg.sv | 24 ++
 rtl/nios_ram_mover_addr_gen.sv | 57 +++++
 rtl/nios_ram_block_mover.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_ram_mover_pkg.sv
// rtl/nios_ram_mover_pkg.sv - shared types and constants for the RAM block mover
// Purpose: FSM state encoding, command opcode encoding and the all-ones
//          byteenable source used by nios_ram_block_mover and its sub-module.
// Ports:   none (package)
package nios_ram_mover_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FILL = 3'd1,
      ST_RD   = 3'd2,
      ST_WAIT = 3'd3,
      ST_WR   = 3'd4,
      ST_FIN  = 3'd5
   } state_e;

   typedef enum logic {
      OP_COPY = 1'b0,
      OP_FILL = 1'b1
   } op_e;

   // Wide enough for any DATA_W up to 1024; the top slices off DATA_W/8 bits.
   localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/nios_ram_mover_addr_gen.sv
// rtl/nios_ram_mover_addr_gen.sv - word counter with wrapping src/dst address adders
// Purpose: holds the word index i of the active transfer and produces
//          src_base+i, dst_base+i (modulo 2**ADDR_W) and a last-word flag.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clr                 zero the word counter (new command accepted)
//   inc                 advance to the next word
//   src_base, dst_base  latched command base addresses
//   len                 latched word count (only meaningful when >= 1)
//   src_word, dst_word  current source / destination word addresses
//   last                current word is the final one of the transfer
module nios_ram_mover_addr_gen
   import nios_ram_mover_pkg::*;
#(
   parameter int ADDR_W = 15,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              inc,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [LEN_W-1:0]  len,
   output logic [ADDR_W-1:0] src_word,
   output logic [ADDR_W-1:0] dst_word,
   output logic              last
);

   logic [LEN_W-1:0]  cnt_q;
   logic [LEN_W-1:0]  cnt_d;
   logic [ADDR_W-1:0] idx;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Sums are kept at ADDR_W bits so the carry out is dropped: addresses wrap.
   assign idx      = ADDR_W'(cnt_q);
   assign src_word = src_base + idx;
   assign dst_word = dst_base + idx;
   assign last     = (cnt_q == (len - LEN_W'(1)));

endmodule

// File: rtl/nios_ram_block_mover.sv
// rtl/nios_ram_block_mover.sv - Avalon-MM master doing RAM block copy / constant fill
// Purpose: on a start strobe copies len words src->dst (read, wait, write per
//          word) or fills len words at dst with a constant, then pulses done
//          and raises a level irq. Drives the RAM port only while granted.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   start, op_fill, src_addr, dst_addr,
//   len, fill_data                       command, sampled when start=1 in IDLE
//   abort                                cancel the active transfer
//   grant                                arbiter grant of the RAM port
//   irq_ack                              clears irq
//   address, chipselect, write,
//   byteenable, writedata, readdata      Avalon-MM master port to the RAM
//   busy, done, aborted, irq             status / interrupt
module nios_ram_block_mover
   import nios_ram_mover_pkg::*;
#(
   parameter int ADDR_W       = 15,
   parameter int DATA_W       = 32,
   parameter int LEN_W        = 16,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                op_fill,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [ADDR_W-1:0]   dst_addr,
   input  logic [LEN_W-1:0]    len,
   input  logic [DATA_W-1:0]   fill_data,
   input  logic                abort,
   input  logic                grant,
   input  logic                irq_ack,
   output logic [ADDR_W-1:0]   address,
   output logic                chipselect,
   output logic                write,
   output logic [DATA_W/8-1:0] byteenable,
   output logic [DATA_W-1:0]   writedata,
   input  logic [DATA_W-1:0]   readdata,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic                irq
);

   localparam int BE_W = DATA_W / 8;
   localparam int WC_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [DATA_W-1:0]   fill_q, fill_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [WC_W-1:0]     wait_q, wait_d;
   logic                aborted_q, aborted_d;
   logic                irq_q, irq_d;

   logic                cnt_clr;
   logic                cnt_inc;
   logic [ADDR_W-1:0]   gen_src;
   logic [ADDR_W-1:0]   gen_dst;
   logic                gen_last;

   logic                cs;
   logic                wr;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;

   nios_ram_mover_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .src_base (src_q),
      .dst_base (dst_q),
      .len      (len_q),
      .src_word (gen_src),
      .dst_word (gen_dst),
      .last     (gen_last)
   );

   // Bus outputs are decoded combinationally from the state so that abort and
   // a dropped grant remove chipselect within the same cycle.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      len_d     = len_q;
      fill_d    = fill_q;
      rdata_d   = rdata_q;
      wait_d    = wait_q;
      aborted_d = aborted_q;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      cs        = 1'b0;
      wr        = 1'b0;
      addr      = '0;
      wdata     = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_d     = src_addr;
               dst_d     = dst_addr;
               len_d     = len;
               fill_d    = fill_data;
               aborted_d = 1'b0;
               cnt_clr   = 1'b1;
               if (len == '0) begin
                  state_d = ST_FIN;
               end else if (op_e'(op_fill) == OP_FILL) begin
                  state_d = ST_FILL;
               end else begin
                  state_d = ST_RD;
               end
            end
         end

         ST_FILL: begin
            if (abort) begin
               state_d   = ST_FIN;
               aborted_d = 1'b1;
            end else if (grant) begin
               cs      = 1'b1;
               wr      = 1'b1;
               addr    = gen_dst;
               wdata   = fill_q;
               cnt_inc = 1'b1;
               if (gen_last) begin
                  state_d = ST_FIN;
               end
            end
         end

         ST_RD: begin
            if (abort) begin
               state_d   = ST_FIN;
               aborted_d = 1'b1;
            end else if (grant) begin
               cs      = 1'b1;
               addr    = gen_src;
               wait_d  = '0;
               state_d = ST_WAIT;
            end
         end

         // Counts regardless of grant: the RAM returns data on a fixed latency.
         ST_WAIT: begin
            if (abort) begin
               state_d   = ST_FIN;
               aborted_d = 1'b1;
            end else if (wait_q == WC_W'(READ_LATENCY - 1)) begin
               rdata_d = readdata;
               state_d = ST_WR;
            end else begin
               wait_d = wait_q + WC_W'(1);
            end
         end

         ST_WR: begin
            if (abort) begin
               state_d   = ST_FIN;
               aborted_d = 1'b1;
            end else if (grant) begin
               cs      = 1'b1;
               wr      = 1'b1;
               addr    = gen_dst;
               wdata   = rdata_q;
               cnt_inc = 1'b1;
               state_d = gen_last ? ST_FIN : ST_RD;
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // irq rises together with done and is held through the done cycle, so
      // an ack coinciding with done cannot clear it.
      irq_d = (irq_q & ~irq_ack)
            | ((state_d == ST_FIN) && (state_q != ST_FIN))
            | (state_q == ST_FIN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         fill_q    <= '0;
         rdata_q   <= '0;
         wait_q    <= '0;
         aborted_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         len_q     <= len_d;
         fill_q    <= fill_d;
         rdata_q   <= rdata_d;
         wait_q    <= wait_d;
         aborted_q <= aborted_d;
         irq_q     <= irq_d;
      end
   end

   assign address    = addr;
   assign chipselect = cs;
   assign write      = wr;
   assign byteenable = cs ? BE_ALL[BE_W-1:0] : '0;
   assign writedata  = wdata;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FIN);
   assign aborted    = aborted_q;
   assign irq        = irq_q;

endmodule
